rr_gnt_responder: RTL and testbench

- Grant-side responder for the single-cycle req/gnt handshake.
- Each cycle it accepts up to N request lines and returns a one-hot grant in the same cycle. This satisfies the overlapping rule "any req |-> some gnt", which makes the arbiter work-conserving.
- Owners are picked round-robin. An owner's tenure is bounded when other requesters are waiting.
- Saturating counters record busy cycles (any req high, a real handshake attempt) and idle cycles (no req, a vacuous cycle) for coverage and bring-up.

---
 rtl/rr_gnt_responder.sv | 100 ++++++++++
 tb/tb_rr_gnt_responder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/rr_gnt_responder.sv
// Round-robin grant responder: same-cycle one-hot grant with bounded owner
// tenure, plus saturating busy/idle cycle counters.
module rr_gnt_responder #(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 4,
  parameter  int CNT_W    = 16,
  localparam int IW       = (N > 1) ? $clog2(N) : 1,
  localparam int HW       = $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [IW-1:0]    gnt_idx,
  input  logic             clear_stats,
  output logic [CNT_W-1:0] busy_cnt,
  output logic [CNT_W-1:0] idle_cnt
);

  logic [IW-1:0] owner;
  logic          owner_valid;
  logic [HW-1:0] hold_cnt;

  logic [N-1:0]  owner_oh;
  logic          others;
  logic          keep;
  logic          found;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < N; i++) owner_oh[i] = (owner == IW'(i));
  end

  assign others = |(req & ~owner_oh);
  assign keep   = owner_valid && (|(req & owner_oh)) &&
                  ((hold_cnt < HW'(MAX_HOLD)) || !others);

  // Scan owner+1 .. owner+N (mod N); the owner itself comes up last.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(owner) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Reset gates the grant combinationally so it drops without a clock edge.
  assign gnt_valid = rst_n && (|req);

  always_comb begin
    gnt_idx = '0;
    if (gnt_valid) gnt_idx = keep ? owner : pick;
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < N; i++) gnt[i] = gnt_valid && (gnt_idx == IW'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner       <= IW'(N - 1);
      owner_valid <= 1'b0;
      hold_cnt    <= '0;
    end else if (!gnt_valid) begin
      // owner is kept so rotation resumes where it left off after idle
      owner_valid <= 1'b0;
      hold_cnt    <= '0;
    end else if (keep) begin
      if (hold_cnt != HW'(MAX_HOLD)) hold_cnt <= hold_cnt + 1'b1;
    end else begin
      owner       <= gnt_idx;
      owner_valid <= 1'b1;
      hold_cnt    <= HW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= '0;
      idle_cnt <= '0;
    end else if (clear_stats) begin
      busy_cnt <= '0;
      idle_cnt <= '0;
    end else if (|req) begin
      if (busy_cnt != '1) busy_cnt <= busy_cnt + 1'b1;
    end else begin
      if (idle_cnt != '1) idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_gnt_responder.sv
// Directed bench for rr_gnt_responder (N=4, MAX_HOLD=4, CNT_W=3).
module tb_rr_gnt_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic       clear_stats;
  logic [2:0] busy_cnt;
  logic [2:0] idle_cnt;

  int checks   = 0;
  int failures = 0;

  rr_gnt_responder #(.N(4), .MAX_HOLD(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .gnt_valid(gnt_valid),
    .gnt_idx(gnt_idx), .clear_stats(clear_stats), .busy_cnt(busy_cnt),
    .idle_cnt(idle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge: drive req, check the same-cycle grant, advance to
  // the next negedge (so the posedge in between has updated the registers).
  task automatic cyc(input logic [3:0] r, input logic [3:0] exp_g, input string tag);
    logic [1:0] ei;
    ei = '0;
    for (int i = 0; i < 4; i++) if (exp_g[i]) ei = 2'(i);
    req = r;
    #1;
    chk({tag, ".gnt"}, 32'(gnt), 32'(exp_g));
    chk({tag, ".vld"}, 32'(gnt_valid), 32'(|exp_g));
    chk({tag, ".idx"}, 32'(gnt_idx), 32'(ei));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    clear_stats = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req = 4'b1111;
    clear_stats = 1'b0;

    // Reset with all requests high, then a lone request
    @(negedge clk);
    #1;
    chk("rst.gnt", 32'(gnt), 32'h0);
    chk("rst.vld", 32'(gnt_valid), 32'h0);
    chk("rst.idx", 32'(gnt_idx), 32'h0);
    chk("rst.busy", 32'(busy_cnt), 32'h0);
    chk("rst.idle", 32'(idle_cnt), 32'h0);
    chk("rst.owner", 32'(dut.owner), 32'h3);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(4'b0001, 4'b0001, "lone0");
    chk("lone0.busy", 32'(busy_cnt), 32'h1);
    chk("lone0.idle", 32'(idle_cnt), 32'h0);

    // Full load: four grants per requester, rotating 0,1,2,3,0
    do_reset();
    for (int c = 0; c < 20; c++)
      cyc(4'b1111, 4'(1 << ((c / 4) % 4)), $sformatf("full%0d", c));

    // Lone holder is never cut off; a new requester forces rotation at once
    do_reset();
    for (int c = 0; c < 10; c++)
      cyc(4'b0010, 4'b0010, $sformatf("hold%0d", c));
    chk("hold.sat", 32'(dut.hold_cnt), 32'h4);
    cyc(4'b1010, 4'b1000, "rot");
    chk("rot.hold", 32'(dut.hold_cnt), 32'h1);
    chk("rot.owner", 32'(dut.owner), 32'h3);

    // Owner drops mid-tenure; round-robin resumes after idle gap
    do_reset();
    cyc(4'b0100, 4'b0100, "drop.a");
    cyc(4'b1101, 4'b0100, "drop.b");
    chk("drop.h2", 32'(dut.hold_cnt), 32'h2);
    cyc(4'b1001, 4'b1000, "drop.c");
    chk("drop.h1", 32'(dut.hold_cnt), 32'h1);
    cyc(4'b0000, 4'b0000, "idle.a");
    cyc(4'b0000, 4'b0000, "idle.b");
    cyc(4'b1111, 4'b0001, "resume");

    // Statistics saturation and clear priority
    do_reset();
    for (int c = 0; c < 3; c++) cyc(4'b0000, 4'b0000, $sformatf("st.idle%0d", c));
    for (int c = 0; c < 10; c++) begin
      req = 4'b1011;
      @(negedge clk);
    end
    chk("st.idle", 32'(idle_cnt), 32'h3);
    chk("st.busy_sat", 32'(busy_cnt), 32'h7);
    clear_stats = 1'b1;
    req = 4'b1111;
    #1;
    chk("st.clr_gnt", 32'(gnt_valid), 32'h1);
    @(negedge clk);
    clear_stats = 1'b0;
    chk("st.clr_busy", 32'(busy_cnt), 32'h0);
    chk("st.clr_idle", 32'(idle_cnt), 32'h0);
    @(negedge clk);
    chk("st.after_busy", 32'(busy_cnt), 32'h1);
    chk("st.after_idle", 32'(idle_cnt), 32'h0);

    // Asynchronous reset in the middle of a tenure
    do_reset();
    cyc(4'b0100, 4'b0100, "ar.a");
    cyc(4'b0100, 4'b0100, "ar.b");
    rst_n = 1'b0;
    #1;
    chk("ar.gnt", 32'(gnt), 32'h0);
    chk("ar.vld", 32'(gnt_valid), 32'h0);
    chk("ar.hold", 32'(dut.hold_cnt), 32'h0);
    chk("ar.owner", 32'(dut.owner), 32'h3);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(4'b0100, 4'b0100, "ar.rel");
    chk("ar.rel_hold", 32'(dut.hold_cnt), 32'h1);
    do_reset();
    cyc(4'b1010, 4'b0010, "ar.order");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
